// File: rtl/sync_fifo_flags.sv
// Single-clock first-word-fall-through FIFO with exact fill level,
// programmable almost-full/almost-empty flags, synchronous flush and sticky
// overflow/underflow error flags. Storage is sync-read RAM; the RAM read
// register doubles as the FWFT output stage.
module sync_fifo_flags #(
    parameter int unsigned W        = 16,
    parameter int unsigned N        = 8,
    parameter int unsigned AF_LEVEL = (1 << N) - 4,
    parameter int unsigned AE_LEVEL = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         w_trigger,
    input  logic [W-1:0] w_data,
    output logic         w_ready,
    input  logic         r_trigger,
    output logic [W-1:0] r_data,
    output logic         r_ready,
    output logic [N:0]   level,
    output logic         almost_full,
    output logic         almost_empty,
    output logic         overflow,
    output logic         underflow
);

    localparam int unsigned DEPTH   = 1 << N;
    localparam logic [N:0]  DEPTH_L = (N+1)'(DEPTH);
    localparam logic [N:0]  AF_L    = (N+1)'(AF_LEVEL);
    localparam logic [N:0]  AE_L    = (N+1)'(AE_LEVEL);

    logic [W-1:0] mem [DEPTH];
    logic [N:0]   wr_ptr;
    logic [N:0]   rd_ptr;
    logic [N-1:0] rd_addr;
    logic [N:0]   level_after_pop;
    logic [N:0]   level_next;
    logic         clr;
    logic         wr_acc;
    logic         rd_acc;

    // Handshake decode, next level and the prefetch address of the next head word
    always_comb begin
        clr             = rst | flush;
        wr_acc          = w_trigger & w_ready;
        rd_acc          = r_trigger & r_ready;
        level_after_pop = level - (N+1)'(rd_acc);
        level_next      = level_after_pop + (N+1)'(wr_acc);
        rd_addr         = clr ? '0 : rd_ptr[N-1:0] + N'(rd_acc);
    end

    // Storage write and registered read of the head word (no reset: RAM inference)
    always_ff @(posedge clk) begin
        if (wr_acc && !clr) begin
            mem[wr_ptr[N-1:0]] <= w_data;
        end
        r_data <= mem[rd_addr];
    end

    // Pointers, level, flags and sticky errors. The head is valid only when it
    // existed before this edge, which also covers a write into the slot being
    // prefetched (RAM returns the old contents on that same-address collision).
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            w_ready      <= 1'b1;
            r_ready      <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + (N+1)'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + (N+1)'(1);
            end
            level        <= level_next;
            w_ready      <= (level_next != DEPTH_L);
            r_ready      <= (level_after_pop != '0);
            almost_full  <= (level_next >= AF_L);
            almost_empty <= (level_next <= AE_L);
            if (w_trigger && !w_ready) begin
                overflow <= 1'b1;
            end
            if (r_trigger && !r_ready) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised and directed bench for sync_fifo_flags (DEPTH=4, AF=3, AE=1).
// A reference model tracks contents as a queue of (data, write-edge) entries;
// a separate monitor pops expected data on every accepted DUT pop.
module tb_sync_fifo_flags;

    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        w_trigger = 1'b0;
    logic [15:0] w_data = '0;
    logic        w_ready;
    logic        r_trigger = 1'b0;
    logic [15:0] r_data;
    logic        r_ready;
    logic [2:0]  level;
    logic        almost_full;
    logic        almost_empty;
    logic        overflow;
    logic        underflow;

    sync_fifo_flags #(.W(16), .N(2), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .w_trigger(w_trigger), .w_data(w_data), .w_ready(w_ready),
        .r_trigger(r_trigger), .r_data(r_data), .r_ready(r_ready),
        .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];   // scoreboard: data expected at DUT pops
    int          stamp_q[$]; // model: write edge of each stored word
    int          edge_n  = 0;
    bit          m_rdy   = 0;
    bit          m_ovf   = 0;
    bit          m_udf   = 0;
    bit          started = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: compare current state, then advance over the coming edge
    always @(negedge clk) begin
        int e;
        bit wacc;
        bit pacc;
        int sz;
        sz = stamp_q.size();
        if (started) begin
            chk("level", int'(level), sz);
            chk("w_ready", int'(w_ready), int'(sz != DEPTH));
            chk("r_ready", int'(r_ready), int'(m_rdy));
            chk("almost_full", int'(almost_full), int'(sz >= AF));
            chk("almost_empty", int'(almost_empty), int'(sz <= AE));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underflow", int'(underflow), int'(m_udf));
        end
        e = edge_n + 1;
        if (rst || flush) begin
            stamp_q.delete();
            exp_q.delete();
            m_rdy   = 0;
            m_ovf   = 0;
            m_udf   = 0;
            started = 1;
        end else begin
            wacc = w_trigger && (sz < DEPTH);
            pacc = r_trigger && m_rdy;
            if (w_trigger && !wacc) m_ovf = 1;
            if (r_trigger && !m_rdy) m_udf = 1;
            if (pacc) void'(stamp_q.pop_front());
            if (wacc) begin
                stamp_q.push_back(e);
                exp_q.push_back(w_data);
            end
            // A word is presentable once it was written at an earlier edge
            m_rdy = (stamp_q.size() > 0) && (stamp_q[0] < e);
        end
        edge_n = e;
    end

    // Monitor: every accepted pop must present the oldest outstanding word
    always @(negedge clk) begin
        logic [15:0] exp_d;
        if (started && !rst && !flush && r_trigger && r_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_on_empty_scoreboard", 1, 0);
            end else begin
                exp_d = exp_q.pop_front();
                chk("r_data", int'(r_data), int'(exp_d));
            end
        end
    end

    task automatic cyc(input bit w, input logic [15:0] d, input bit r,
                       input bit rs, input bit fl);
        w_trigger = w;
        w_data    = d;
        r_trigger = r;
        rst       = rs;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 16'h0, 0, 0, 0);
    endtask

    initial begin
        #1;
        cyc(0, 16'h0, 0, 1, 0);
        cyc(0, 16'h0, 0, 1, 0);
        idle(1);

        // Single write: level next cycle, data one cycle later
        cyc(1, 16'hA001, 0, 0, 0);
        idle(2);
        cyc(0, 16'h0, 1, 0, 0);
        idle(2);

        // Fill past full, then drain back-to-back
        for (int i = 1; i <= 5; i++) cyc(1, 16'(i), 0, 0, 0);
        idle(2);
        for (int i = 0; i < 4; i++) cyc(0, 16'h0, 1, 0, 0);
        idle(2);
        cyc(0, 16'h0, 0, 0, 1);

        // Level 2, then simultaneous write+pop across many pointer wraps
        cyc(1, 16'h0100, 0, 0, 0);
        cyc(1, 16'h0101, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 20; i++) cyc(1, 16'(16'h0102 + i), 1, 0, 0);
        cyc(0, 16'h0, 1, 0, 0);
        cyc(0, 16'h0, 1, 0, 0);
        idle(2);

        // Full with same-edge pop and write
        for (int i = 0; i < 4; i++) cyc(1, 16'(16'h0200 + i), 0, 0, 0);
        idle(2);
        cyc(1, 16'h02FF, 1, 0, 0);
        idle(2);
        cyc(0, 16'h0, 0, 0, 1);
        idle(1);

        // Underflow on empty, then flush overriding a write
        cyc(0, 16'h0, 1, 0, 0);
        idle(1);
        cyc(1, 16'h0300, 0, 0, 1);
        idle(3);

        // Reset mid-stream with a concurrent pop, then reuse
        for (int i = 0; i < 3; i++) cyc(1, 16'(16'h0400 + i), 0, 0, 0);
        idle(2);
        cyc(0, 16'h0, 1, 1, 0);
        idle(1);
        cyc(1, 16'hBEEF, 0, 0, 0);
        idle(2);
        cyc(0, 16'h0, 1, 0, 0);
        idle(2);

        // Random traffic with occasional flush
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 10) < 6, 16'($urandom), ($urandom % 10) < 5,
                0, ($urandom % 64) == 0);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
